// File: rtl/pacman_mover_if.sv
// Maze lookup and dot-eat signals between the player mover and the maze block.
interface pacman_mover_if;
  logic [4:0] query_x;
  logic [3:0] query_y;
  logic       is_wall;
  logic       has_dot;
  logic       eat_dot;
  logic [4:0] eat_x;
  logic [3:0] eat_y;

  modport master (
    output query_x, query_y, eat_dot, eat_x, eat_y,
    input  is_wall, has_dot
  );

  modport slave (
    input  query_x, query_y, eat_dot, eat_x, eat_y,
    output is_wall, has_dot
  );
endinterface

// File: rtl/pacman_mover.sv
// Grid-stepping movement controller for the player sprite: divides move ticks into cell steps,
// tries a buffered turn before going straight, and eats dots on the cells it enters.
module pacman_mover #(
  parameter int unsigned STEP_DIV  = 8,
  parameter int unsigned START_X   = 9,
  parameter int unsigned START_Y   = 13,
  parameter int unsigned START_DIR = 2,
  parameter logic [15:0] SCORE_INC = 16'd10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           game_reset,
  input  logic           move_tick,
  input  logic [1:0]     dir_req,
  input  logic           dir_req_valid,
  pacman_mover_if.master maze,
  output logic [4:0]     pac_x,
  output logic [3:0]     pac_y,
  output logic [1:0]     pac_dir,
  output logic           moving,
  output logic [15:0]    score
);

  typedef enum logic [2:0] {StIdle, StTurnQ, StFwdQ, StDotQ, StEat} state_e;

  localparam logic [4:0] StartX   = 5'(START_X);
  localparam logic [3:0] StartY   = 4'(START_Y);
  localparam logic [1:0] StartDir = 2'(START_DIR);
  localparam logic [7:0] LastTick = 8'(STEP_DIV - 1);

  state_e      state_q, state_d;
  logic [4:0]  pac_x_q, pac_x_d, query_x_q, query_x_d, eat_x_q, eat_x_d;
  logic [3:0]  pac_y_q, pac_y_d, query_y_q, query_y_d, eat_y_q, eat_y_d;
  logic [1:0]  pac_dir_q, pac_dir_d, pend_dir_q, pend_dir_d;
  logic        pend_valid_q, pend_valid_d;
  logic        oob_q, oob_d;
  logic        moving_q, moving_d;
  logic        eat_dot_q, eat_dot_d;
  logic [7:0]  tick_cnt_q, tick_cnt_d;
  logic [15:0] score_q, score_d;
  logic        trigger;
  logic [9:0]  nb_pend, nb_fwd;
  logic [16:0] score_sum;

  // Returns {off_grid, x, y}; an off-grid neighbour keeps the current cell so no bogus query is
  // ever presented to the maze.
  function automatic logic [9:0] neighbour(input logic [4:0] x, input logic [3:0] y,
                                           input logic [1:0] dir);
    logic       oob;
    logic [4:0] nx;
    logic [3:0] ny;
    oob = 1'b0;
    nx  = x;
    ny  = y;
    case (dir)
      2'd0:    if (x >= 5'd19) oob = 1'b1; else nx = x + 5'd1;
      2'd1:    if (y == 4'd0)  oob = 1'b1; else ny = y - 4'd1;
      2'd2:    if (x == 5'd0)  oob = 1'b1; else nx = x - 5'd1;
      default: if (y >= 4'd14) oob = 1'b1; else ny = y + 4'd1;
    endcase
    return {oob, nx, ny};
  endfunction

  assign trigger   = move_tick && (tick_cnt_q == LastTick);
  assign nb_pend   = neighbour(pac_x_q, pac_y_q, pend_dir_q);
  assign nb_fwd    = neighbour(pac_x_q, pac_y_q, pac_dir_q);
  assign score_sum = {1'b0, score_q} + {1'b0, SCORE_INC};

  always_comb begin
    state_d      = state_q;
    pac_x_d      = pac_x_q;
    pac_y_d      = pac_y_q;
    pac_dir_d    = pac_dir_q;
    pend_dir_d   = pend_dir_q;
    pend_valid_d = pend_valid_q;
    query_x_d    = query_x_q;
    query_y_d    = query_y_q;
    oob_d        = oob_q;
    moving_d     = moving_q;
    eat_dot_d    = eat_dot_q;
    eat_x_d      = eat_x_q;
    eat_y_d      = eat_y_q;
    tick_cnt_d   = tick_cnt_q;
    score_d      = score_q;

    // The counter clears on every step trigger, even one dropped because a step is in flight.
    if (move_tick) tick_cnt_d = trigger ? 8'd0 : tick_cnt_q + 8'd1;

    case (state_q)
      StIdle: begin
        if (trigger) begin
          if (pend_valid_q) begin
            {oob_d, query_x_d, query_y_d} = nb_pend;
            state_d = StTurnQ;
          end else begin
            {oob_d, query_x_d, query_y_d} = nb_fwd;
            state_d = StFwdQ;
          end
        end
      end
      StTurnQ: begin
        if (!oob_q && !maze.is_wall) begin
          pac_x_d      = query_x_q;
          pac_y_d      = query_y_q;
          pac_dir_d    = pend_dir_q;
          pend_valid_d = 1'b0;
          moving_d     = 1'b1;
          state_d      = StDotQ;
        end else begin
          {oob_d, query_x_d, query_y_d} = nb_fwd;
          state_d = StFwdQ;
        end
      end
      StFwdQ: begin
        if (!oob_q && !maze.is_wall) begin
          pac_x_d  = query_x_q;
          pac_y_d  = query_y_q;
          moving_d = 1'b1;
        end else begin
          query_x_d = pac_x_q;
          query_y_d = pac_y_q;
          oob_d     = 1'b0;
          moving_d  = 1'b0;
        end
        state_d = (!oob_q && !maze.is_wall) ? StDotQ : StIdle;
      end
      StDotQ: begin
        if (maze.has_dot) begin
          eat_x_d   = pac_x_q;
          eat_y_d   = pac_y_q;
          eat_dot_d = 1'b1;
          state_d   = StEat;
        end else begin
          state_d = StIdle;
        end
      end
      StEat: begin
        eat_dot_d = 1'b0;
        score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (dir_req_valid) begin
      pend_dir_d   = dir_req;
      pend_valid_d = 1'b1;
    end

    if (game_reset) begin
      state_d      = StIdle;
      pac_x_d      = StartX;
      pac_y_d      = StartY;
      pac_dir_d    = StartDir;
      pend_dir_d   = 2'd0;
      pend_valid_d = 1'b0;
      query_x_d    = StartX;
      query_y_d    = StartY;
      oob_d        = 1'b0;
      moving_d     = 1'b0;
      eat_dot_d    = 1'b0;
      eat_x_d      = 5'd0;
      eat_y_d      = 4'd0;
      tick_cnt_d   = 8'd0;
      score_d      = 16'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pac_x_q      <= StartX;
      pac_y_q      <= StartY;
      pac_dir_q    <= StartDir;
      pend_dir_q   <= 2'd0;
      pend_valid_q <= 1'b0;
      query_x_q    <= StartX;
      query_y_q    <= StartY;
      oob_q        <= 1'b0;
      moving_q     <= 1'b0;
      eat_dot_q    <= 1'b0;
      eat_x_q      <= 5'd0;
      eat_y_q      <= 4'd0;
      tick_cnt_q   <= 8'd0;
      score_q      <= 16'd0;
    end else begin
      state_q      <= state_d;
      pac_x_q      <= pac_x_d;
      pac_y_q      <= pac_y_d;
      pac_dir_q    <= pac_dir_d;
      pend_dir_q   <= pend_dir_d;
      pend_valid_q <= pend_valid_d;
      query_x_q    <= query_x_d;
      query_y_q    <= query_y_d;
      oob_q        <= oob_d;
      moving_q     <= moving_d;
      eat_dot_q    <= eat_dot_d;
      eat_x_q      <= eat_x_d;
      eat_y_q      <= eat_y_d;
      tick_cnt_q   <= tick_cnt_d;
      score_q      <= score_d;
    end
  end

  assign maze.query_x = query_x_q;
  assign maze.query_y = query_y_q;
  assign maze.eat_dot = eat_dot_q;
  assign maze.eat_x   = eat_x_q;
  assign maze.eat_y   = eat_y_q;
  assign pac_x        = pac_x_q;
  assign pac_y        = pac_y_q;
  assign pac_dir      = pac_dir_q;
  assign moving       = moving_q;
  assign score        = score_q;

endmodule

// File: tb/tb_pacman_mover.sv
// Directed bench for pacman_mover: a small maze model, a table of per-step vectors, and
// hand-written reset, restart and score-saturation sequences.
module tb_pacman_mover;
  logic        clk = 1'b0;
  logic        rst, game_reset, move_tick, dir_req_valid, tick2, maze_init;
  logic [1:0]  dir_req;
  logic [4:0]  pac_x, pac_x2;
  logic [3:0]  pac_y, pac_y2;
  logic [1:0]  pac_dir, pac_dir2;
  logic        moving, moving2;
  logic [15:0] score, score2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pacman_mover_if mif ();
  pacman_mover_if mif2 ();

  pacman_mover dut (
    .clk(clk), .rst(rst), .game_reset(game_reset), .move_tick(move_tick),
    .dir_req(dir_req), .dir_req_valid(dir_req_valid), .maze(mif),
    .pac_x(pac_x), .pac_y(pac_y), .pac_dir(pac_dir), .moving(moving), .score(score)
  );

  pacman_mover #(.STEP_DIV(1), .SCORE_INC(16'h8000)) dut_sat (
    .clk(clk), .rst(rst), .game_reset(1'b0), .move_tick(tick2),
    .dir_req(2'd0), .dir_req_valid(1'b0), .maze(mif2),
    .pac_x(pac_x2), .pac_y(pac_y2), .pac_dir(pac_dir2), .moving(moving2), .score(score2)
  );

  // Maze model: column 0 and cell (9,12) are walls, every open cell starts with a dot.
  logic       dot_map [20][15];
  int         eat_cnt = 0;
  logic [4:0] last_eat_x;
  logic [3:0] last_eat_y;

  function automatic logic wall_at(input logic [4:0] x, input logic [3:0] y);
    return (x == 5'd0) || (x == 5'd9 && y == 4'd12);
  endfunction

  always_comb begin
    if (mif.query_x > 5'd19 || mif.query_y > 4'd14) begin
      // Off-grid reads look open so a missing bound check moves the sprite off the grid.
      mif.is_wall = 1'b0;
      mif.has_dot = 1'b1;
    end else begin
      mif.is_wall = wall_at(mif.query_x, mif.query_y);
      mif.has_dot = dot_map[mif.query_x][mif.query_y];
    end
  end

  always @(posedge clk) begin
    if (maze_init) begin
      for (int x = 0; x < 20; x++)
        for (int y = 0; y < 15; y++) dot_map[x][y] <= 1'b1;
    end else if (mif.eat_dot) begin
      eat_cnt    <= eat_cnt + 1;
      last_eat_x <= mif.eat_x;
      last_eat_y <= mif.eat_y;
      if (mif.eat_x < 5'd20 && mif.eat_y < 4'd15) dot_map[mif.eat_x][mif.eat_y] <= 1'b0;
    end
  end

  assign mif2.is_wall = (mif2.query_x == 5'd0);
  assign mif2.has_dot = 1'b1;

  typedef struct {
    int          nreq;
    logic [1:0]  req0;
    logic [1:0]  req1;
    logic [4:0]  x;
    logic [3:0]  y;
    logic [1:0]  dir;
    logic        mov;
    logic [15:0] score;
    int          eats;
    logic [4:0]  ex;
    logic [3:0]  ey;
  } vec_t;

  vec_t vecs [16];

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic request(input logic [1:0] d);
    dir_req       = d;
    dir_req_valid = 1'b1;
    cyc();
    dir_req_valid = 1'b0;
  endtask

  task automatic tick();
    move_tick = 1'b1;
    cyc();
    move_tick = 1'b0;
    cyc();
  endtask

  task automatic step();
    repeat (8) tick();
    cyc(8);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pac_x"}, 0, 32'(pac_x), 32'd9);
    check({tag, "_pac_y"}, 0, 32'(pac_y), 32'd13);
    check({tag, "_pac_dir"}, 0, 32'(pac_dir), 32'd2);
    check({tag, "_moving"}, 0, 32'(moving), 32'd0);
    check({tag, "_score"}, 0, 32'(score), 32'd0);
    check({tag, "_query_x"}, 0, 32'(mif.query_x), 32'd9);
    check({tag, "_query_y"}, 0, 32'(mif.query_y), 32'd13);
    check({tag, "_eat_dot"}, 0, 32'(mif.eat_dot), 32'd0);
    check({tag, "_eat_x"}, 0, 32'(mif.eat_x), 32'd0);
    check({tag, "_eat_y"}, 0, 32'(mif.eat_y), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    //          nreq r0    r1    x      y      dir   mov   score    eats ex     ey
    vecs[0]  = '{1, 2'd1, 2'd0, 5'd8, 4'd13, 2'd2, 1'b1, 16'd10,  1, 5'd8, 4'd13};
    vecs[1]  = '{0, 2'd0, 2'd0, 5'd8, 4'd12, 2'd1, 1'b1, 16'd20,  1, 5'd8, 4'd12};
    vecs[2]  = '{1, 2'd3, 2'd0, 5'd8, 4'd13, 2'd3, 1'b1, 16'd20,  0, 5'd0, 4'd0};
    vecs[3]  = '{1, 2'd2, 2'd0, 5'd7, 4'd13, 2'd2, 1'b1, 16'd30,  1, 5'd7, 4'd13};
    vecs[4]  = '{0, 2'd0, 2'd0, 5'd6, 4'd13, 2'd2, 1'b1, 16'd40,  1, 5'd6, 4'd13};
    vecs[5]  = '{0, 2'd0, 2'd0, 5'd5, 4'd13, 2'd2, 1'b1, 16'd50,  1, 5'd5, 4'd13};
    vecs[6]  = '{0, 2'd0, 2'd0, 5'd4, 4'd13, 2'd2, 1'b1, 16'd60,  1, 5'd4, 4'd13};
    vecs[7]  = '{0, 2'd0, 2'd0, 5'd3, 4'd13, 2'd2, 1'b1, 16'd70,  1, 5'd3, 4'd13};
    vecs[8]  = '{0, 2'd0, 2'd0, 5'd2, 4'd13, 2'd2, 1'b1, 16'd80,  1, 5'd2, 4'd13};
    vecs[9]  = '{0, 2'd0, 2'd0, 5'd1, 4'd13, 2'd2, 1'b1, 16'd90,  1, 5'd1, 4'd13};
    vecs[10] = '{0, 2'd0, 2'd0, 5'd1, 4'd13, 2'd2, 1'b0, 16'd90,  0, 5'd0, 4'd0};
    vecs[11] = '{2, 2'd1, 2'd0, 5'd2, 4'd13, 2'd0, 1'b1, 16'd90,  0, 5'd0, 4'd0};
    vecs[12] = '{0, 2'd0, 2'd0, 5'd3, 4'd13, 2'd0, 1'b1, 16'd90,  0, 5'd0, 4'd0};
    vecs[13] = '{1, 2'd2, 2'd0, 5'd2, 4'd13, 2'd2, 1'b1, 16'd90,  0, 5'd0, 4'd0};
    vecs[14] = '{1, 2'd3, 2'd0, 5'd2, 4'd14, 2'd3, 1'b1, 16'd100, 1, 5'd2, 4'd14};
    vecs[15] = '{0, 2'd0, 2'd0, 5'd2, 4'd14, 2'd3, 1'b0, 16'd100, 0, 5'd0, 4'd0};

    rst = 1'b1; maze_init = 1'b1; game_reset = 1'b0; move_tick = 1'b0;
    dir_req = 2'd0; dir_req_valid = 1'b0; tick2 = 1'b0;
    cyc(3);
    rst = 1'b0; maze_init = 1'b0;
    cyc();
    check_reset_state("reset");

    for (int i = 0; i < 16; i++) begin
      e0 = eat_cnt;
      if (vecs[i].nreq > 0) request(vecs[i].req0);
      if (vecs[i].nreq > 1) request(vecs[i].req1);
      step();
      check("step_pac_x", i, 32'(pac_x), 32'(vecs[i].x));
      check("step_pac_y", i, 32'(pac_y), 32'(vecs[i].y));
      check("step_pac_dir", i, 32'(pac_dir), 32'(vecs[i].dir));
      check("step_moving", i, 32'(moving), 32'(vecs[i].mov));
      check("step_score", i, 32'(score), 32'(vecs[i].score));
      check("step_eats", i, 32'(eat_cnt - e0), 32'(vecs[i].eats));
      if (vecs[i].eats == 1) begin
        check("step_eat_x", i, 32'(last_eat_x), 32'(vecs[i].ex));
        check("step_eat_y", i, 32'(last_eat_y), 32'(vecs[i].ey));
      end
    end

    // Abort a step with async rst while the new cell's dot is being looked up.
    request(2'd2);
    repeat (8) tick();
    check("abort_pre_x", 0, 32'(pac_x), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_state("async_rst");
    e0 = eat_cnt;
    cyc(2);
    rst = 1'b0;
    cyc(8);
    check("abort_no_eat", 0, 32'(eat_cnt - e0), 32'd0);
    check("abort_post_x", 0, 32'(pac_x), 32'd9);

    // Synchronous restart, including the tick divider phase.
    request(2'd3);
    step();
    check("pre_gr_y", 0, 32'(pac_y), 32'd14);
    check("pre_gr_score", 0, 32'(score), 32'd10);
    repeat (3) tick();
    game_reset = 1'b1;
    cyc();
    game_reset = 1'b0;
    check_reset_state("game_reset");
    repeat (7) tick();
    cyc(4);
    check("gr_no_early_step", 0, 32'(pac_x), 32'd9);
    tick();
    cyc(6);
    check("gr_step_x", 0, 32'(pac_x), 32'd8);
    check("gr_step_moving", 0, 32'(moving), 32'd1);
    check("gr_step_score", 0, 32'(score), 32'd0);

    // Score saturation on the second instance.
    for (int k = 0; k < 3; k++) begin
      tick2 = 1'b1;
      cyc();
      tick2 = 1'b0;
      cyc(6);
      check("sat_score", k, 32'(score2), (k == 0) ? 32'h8000 : 32'hFFFF);
    end
    check("sat_pac_x", 0, 32'(pac_x2), 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
